// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster constants and counter widths for the video timing
// generator and the pixel consumers that decode its hcount/vcount.
package video_timing_pkg;

  localparam int VTG_ACTIVE_H = 1280;
  localparam int VTG_H_FRONT  = 110;
  localparam int VTG_H_SYNC   = 40;
  localparam int VTG_H_BACK   = 220;
  localparam int VTG_ACTIVE_V = 720;
  localparam int VTG_V_FRONT  = 5;
  localparam int VTG_V_SYNC   = 5;
  localparam int VTG_V_BACK   = 20;
  localparam int VTG_FPS      = 60;

  localparam int H_TOTAL = VTG_ACTIVE_H + VTG_H_FRONT + VTG_H_SYNC + VTG_H_BACK;
  localparam int V_TOTAL = VTG_ACTIVE_V + VTG_V_FRONT + VTG_V_SYNC + VTG_V_BACK;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int FC_W     = 6;

endpackage

// File: rtl/video_timing_gen.sv
// Free-running raster timing: cascaded h/v counters, sync/active/new-frame flags
// and a frame counter. VTG_SYNC_INVERT_EN makes hs_out/vs_out active-low.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H = VTG_ACTIVE_H,
  parameter int H_FRONT  = VTG_H_FRONT,
  parameter int H_SYNC   = VTG_H_SYNC,
  parameter int H_BACK   = VTG_H_BACK,
  parameter int ACTIVE_V = VTG_ACTIVE_V,
  parameter int V_FRONT  = VTG_V_FRONT,
  parameter int V_SYNC   = VTG_V_SYNC,
  parameter int V_BACK   = VTG_V_BACK,
  parameter int FPS      = VTG_FPS
) (
  input  logic                clk_pixel_in,
  input  logic                rst_n_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out
);

  localparam int H_TOT = ACTIVE_H + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = ACTIVE_V + V_FRONT + V_SYNC + V_BACK;

  if (H_TOT > 2048 || V_TOT > 1024 || FPS > 64) begin : g_bad_cfg
    $error("video_timing_gen: raster or frame rate exceeds counter widths");
  end

  localparam logic [HCOUNT_W-1:0] H_LAST   = HCOUNT_W'(H_TOT - 1);
  localparam logic [HCOUNT_W-1:0] H_ACT    = HCOUNT_W'(ACTIVE_H);
  localparam logic [HCOUNT_W-1:0] HS_START = HCOUNT_W'(ACTIVE_H + H_FRONT);
  localparam logic [HCOUNT_W-1:0] HS_END   = HCOUNT_W'(ACTIVE_H + H_FRONT + H_SYNC);
  localparam logic [VCOUNT_W-1:0] V_LAST   = VCOUNT_W'(V_TOT - 1);
  localparam logic [VCOUNT_W-1:0] V_ACT    = VCOUNT_W'(ACTIVE_V);
  localparam logic [VCOUNT_W-1:0] VS_START = VCOUNT_W'(ACTIVE_V + V_FRONT);
  localparam logic [VCOUNT_W-1:0] VS_END   = VCOUNT_W'(ACTIVE_V + V_FRONT + V_SYNC);
  localparam logic [FC_W-1:0]     FC_LAST  = FC_W'(FPS - 1);

`ifdef VTG_SYNC_INVERT_EN
  localparam logic SYNC_POL = 1'b1;
`else
  localparam logic SYNC_POL = 1'b0;
`endif

  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  logic                hs_q, hs_d;
  logic                vs_q, vs_d;
  logic                ad_q, ad_d;
  logic                nf_q, nf_d;
  logic [FC_W-1:0]     fc_q, fc_d;

  // Flags are decoded from the next count so they land in the same cycle as it.
  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
    end
    ad_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
    hs_d = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ^ SYNC_POL;
    vs_d = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ^ SYNC_POL;
    nf_d = (hcount_d == H_ACT) && (vcount_d == V_ACT);
    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end
  end

  // Reset parks on the last pixel so the first edge after release lands on (0,0).
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_q <= H_LAST;
      vcount_q <= V_LAST;
      hs_q     <= SYNC_POL;
      vs_q     <= SYNC_POL;
      ad_q     <= 1'b0;
      nf_q     <= 1'b0;
      fc_q     <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      ad_q     <= ad_d;
      nf_q     <= nf_d;
      fc_q     <= fc_d;
    end
  end

  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  assign fc_out     = fc_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a full 720p instance plus a shrunken raster
// instance so whole frames, nf spacing and fc wrap fit in a short run.
module tb_video_timing_gen;

  localparam int S_AH = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_AV = 4, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_FPS = 4;
  localparam int NRUN = 3400;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] h_f, h_s;
  logic [9:0]  v_f, v_s;
  logic        hs_f, vs_f, ad_f, nf_f, hs_s, vs_s, ad_s, nf_s;
  logic [5:0]  fc_f, fc_s;

  video_timing_gen dut_full (
    .clk_pixel_in(clk), .rst_n_in(rst_n),
    .hcount_out(h_f), .vcount_out(v_f), .hs_out(hs_f), .vs_out(vs_f),
    .ad_out(ad_f), .nf_out(nf_f), .fc_out(fc_f)
  );

  video_timing_gen #(
    .ACTIVE_H(S_AH), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .ACTIVE_V(S_AV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .FPS(S_FPS)
  ) dut_small (
    .clk_pixel_in(clk), .rst_n_in(rst_n),
    .hcount_out(h_s), .vcount_out(v_s), .hs_out(hs_s), .vs_out(vs_s),
    .ad_out(ad_s), .nf_out(nf_s), .fc_out(fc_s)
  );

  typedef struct {
    int          dut;
    int          n;
    logic [10:0] h;
    logic [9:0]  v;
    logic        hs, vs, ad, nf;
    logic [5:0]  fc;
    string       name;
  } exp_t;

  exp_t tbl[18];
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  // per-dut raster parameters: AH HF HS HB AV VF VS VB FPS
  int prm[2][9];
  int mh[2], mv[2], mfc[2];

  function automatic logic pol(input logic x);
`ifdef VTG_SYNC_INVERT_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  function automatic exp_t mk(input int d, input int n, input int h, input int v,
                              input logic hs, input logic vs, input logic ad,
                              input logic nf, input int fc, input string name);
    exp_t e;
    e.dut = d; e.n = n; e.h = 11'(h); e.v = 10'(v);
    e.hs = pol(hs); e.vs = pol(vs); e.ad = ad; e.nf = nf; e.fc = 6'(fc);
    e.name = name;
    return e;
  endfunction

  function automatic int htot(input int d);
    return prm[d][0] + prm[d][1] + prm[d][2] + prm[d][3];
  endfunction

  function automatic int vtot(input int d);
    return prm[d][4] + prm[d][5] + prm[d][6] + prm[d][7];
  endfunction

  function automatic exp_t reset_exp(input int d, input string name);
    return mk(d, 0, htot(d) - 1, vtot(d) - 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, name);
  endfunction

  task automatic model_reset(input int d);
    mh[d] = htot(d) - 1;
    mv[d] = vtot(d) - 1;
    mfc[d] = 0;
  endtask

  task automatic model_step(input int d, input int n, output exp_t e);
    logic hs, vs, ad, nf;
    if (mh[d] == htot(d) - 1) begin
      mh[d] = 0;
      mv[d] = (mv[d] == vtot(d) - 1) ? 0 : mv[d] + 1;
    end else begin
      mh[d] = mh[d] + 1;
    end
    ad = (mh[d] < prm[d][0]) && (mv[d] < prm[d][4]);
    hs = (mh[d] >= prm[d][0] + prm[d][1]) && (mh[d] < prm[d][0] + prm[d][1] + prm[d][2]);
    vs = (mv[d] >= prm[d][4] + prm[d][5]) && (mv[d] < prm[d][4] + prm[d][5] + prm[d][6]);
    nf = (mh[d] == prm[d][0]) && (mv[d] == prm[d][4]);
    if (nf) mfc[d] = (mfc[d] + 1) % prm[d][8];
    e = mk(d, n, mh[d], mv[d], hs, vs, ad, nf, mfc[d], "model");
  endtask

  task automatic check_vec(input exp_t e);
    logic [10:0] h; logic [9:0] v; logic hs, vs, ad, nf; logic [5:0] fc;
    if (e.dut == 0) begin
      h = h_f; v = v_f; hs = hs_f; vs = vs_f; ad = ad_f; nf = nf_f; fc = fc_f;
    end else begin
      h = h_s; v = v_s; hs = hs_s; vs = vs_s; ad = ad_s; nf = nf_s; fc = fc_s;
    end
    checks++;
    if ({h, v, hs, vs, ad, nf, fc} !== {e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc}) begin
      failures++;
      $display("FAIL %s dut=%0d n=%0d got h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d exp h=%0d v=%0d hs=%b vs=%b ad=%b nf=%b fc=%0d",
               e.name, e.dut, e.n, h, v, hs, vs, ad, nf, fc,
               e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // One clock: advance both models, queue their predictions, compare mid-cycle.
  task automatic cycle(input int n);
    exp_t e;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      model_step(d, n, e);
      sbq.push_back(e);
    end
    @(negedge clk);
    while (sbq.size() > 0) check_vec(sbq.pop_front());
  endtask

  initial begin
    int ti, hs_cnt, vs_cnt, nf_k, last_nf, found;
    exp_t e;

    prm[0] = '{1280, 110, 40, 220, 720, 5, 5, 20, 60};
    prm[1] = '{S_AH, S_HF, S_HS, S_HB, S_AV, S_VF, S_VS, S_VB, S_FPS};

    tbl[0]  = mk(0, 1,    0,    0, 0, 0, 1, 0, 0, "first_pixel");
    tbl[1]  = mk(1, 11,   10,   0, 1, 0, 0, 0, 0, "s_hs_start");
    tbl[2]  = mk(1, 14,   13,   0, 0, 0, 0, 0, 0, "s_hs_end");
    tbl[3]  = mk(1, 69,   8,    4, 0, 0, 0, 1, 1, "s_nf_first");
    tbl[4]  = mk(1, 70,   9,    4, 0, 0, 0, 0, 1, "s_nf_single");
    tbl[5]  = mk(1, 76,   0,    5, 0, 1, 0, 0, 1, "s_vs_start");
    tbl[6]  = mk(1, 120,  14,   7, 0, 0, 0, 0, 1, "s_frame_last");
    tbl[7]  = mk(1, 121,  0,    0, 0, 0, 1, 0, 1, "s_frame_wrap");
    tbl[8]  = mk(1, 429,  8,    4, 0, 0, 0, 1, 0, "s_fc_wrap");
    tbl[9]  = mk(0, 1280, 1279, 0, 0, 0, 1, 0, 0, "last_active");
    tbl[10] = mk(0, 1281, 1280, 0, 0, 0, 0, 0, 0, "first_blank");
    tbl[11] = mk(0, 1390, 1389, 0, 0, 0, 0, 0, 0, "pre_hs");
    tbl[12] = mk(0, 1391, 1390, 0, 1, 0, 0, 0, 0, "hs_start");
    tbl[13] = mk(0, 1430, 1429, 0, 1, 0, 0, 0, 0, "hs_last");
    tbl[14] = mk(0, 1431, 1430, 0, 0, 0, 0, 0, 0, "hs_end");
    tbl[15] = mk(0, 1650, 1649, 0, 0, 0, 0, 0, 0, "line_last");
    tbl[16] = mk(0, 1651, 0,    1, 0, 0, 1, 0, 0, "line_wrap");
    tbl[17] = mk(0, 3301, 0,    2, 0, 0, 1, 0, 0, "line2");

    #1 rst_n = 1'b0;
    #1;
    check_vec(reset_exp(0, "reset_async_full"));
    check_vec(reset_exp(1, "reset_async_small"));
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_vec(reset_exp(0, "reset_hold_full"));
    check_vec(reset_exp(1, "reset_hold_small"));
    rst_n = 1'b1;
    model_reset(0);
    model_reset(1);

    ti = 0; hs_cnt = 0; vs_cnt = 0; nf_k = 0; last_nf = 0;
    for (int n = 1; n <= NRUN; n++) begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        model_step(d, n, e);
        sbq.push_back(e);
      end
      if (ti < 18 && tbl[ti].n == n) begin
        sbq.push_back(tbl[ti]);
        ti++;
      end
      @(negedge clk);
      while (sbq.size() > 0) check_vec(sbq.pop_front());
      if (n <= 1650 && hs_f == pol(1'b1)) hs_cnt++;
      if (n <= 120 && vs_s == pol(1'b1)) vs_cnt++;
      if (nf_s) begin
        nf_k++;
        check_int("s_nf_fc", int'(fc_s), nf_k % S_FPS);
        if (last_nf > 0) check_int("s_nf_spacing", n - last_nf, 120);
        last_nf = n;
      end
    end
    check_int("hs_cycles_per_line", hs_cnt, 40);
    check_int("s_vs_cycles_per_frame", vs_cnt, S_VS * 15);
    check_int("s_nf_pulses", nf_k, (NRUN - 69) / 120 + 1);

    // Async reset mid-frame at small-raster (5,3) with fc=2
    found = 0;
    for (int n = 1; n <= 1000 && found == 0; n++) begin
      cycle(NRUN + n);
      if (mh[1] == 5 && mv[1] == 3 && mfc[1] == 2) found = 1;
    end
    check_int("s_midframe_reached", found, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_vec(reset_exp(0, "midframe_reset_full"));
    check_vec(reset_exp(1, "midframe_reset_small"));
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_vec(reset_exp(1, "midframe_hold_small"));
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_vec(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, "restart_full"));
    check_vec(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, "restart_small"));
    for (int d = 0; d < 2; d++) begin
      model_step(d, 1, e);
    end
    for (int n = 2; n <= 150; n++) cycle(n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=expired exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
